// File: rtl/instruction_fetch_unit.sv
// IF stage: PC register, loadable async-read instruction memory, registered IF/ID outputs.
// Optional HALT detection is compiled in when the IF_HALT_EN macro is defined.
module instruction_fetch_unit #(
    parameter int                    PC_WIDTH   = 8,
    parameter int                    INST_WIDTH = 32,
    parameter int                    MEM_DEPTH  = 256,
    parameter logic [INST_WIDTH-1:0] HALT_WORD  = {INST_WIDTH{1'b1}}
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  i_stall,
    input  logic                  i_PCSrc,
    input  logic [PC_WIDTH-1:0]   i_PCBranch,
    input  logic                  i_jump,
    input  logic [PC_WIDTH-1:0]   i_jump_addr,
    input  logic                  i_write_inst_mem,
    input  logic [PC_WIDTH-1:0]   i_inst_mem_addr,
    input  logic [INST_WIDTH-1:0] i_inst_mem_data,
    output logic [PC_WIDTH-1:0]   o_PCNext,
    output logic [INST_WIDTH-1:0] o_instruction,
    output logic                  o_valid,
    output logic                  o_halted
);

    localparam int AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    // Wide enough to hold both any PC value and MEM_DEPTH itself for range compares.
    localparam int XW = ((PC_WIDTH > AW) ? PC_WIDTH : AW) + 1;

`ifdef IF_HALT_EN
    localparam bit HALT_EN = 1'b1;
`else
    localparam bit HALT_EN = 1'b0;
`endif

    logic [INST_WIDTH-1:0] mem [MEM_DEPTH];

    logic [PC_WIDTH-1:0]   pc_p0,      pc_d;
    logic [INST_WIDTH-1:0] inst_p1,    inst_d;
    logic [PC_WIDTH-1:0]   pc_next_p1, pc_next_d;
    logic                  vld_p1,     vld_d;
    logic                  halted_p1,  halted_d;

    logic [XW-1:0]         pc_ext;
    logic [XW-1:0]         wr_ext;
    logic                  fetch_in_range;
    logic                  wr_in_range;
    logic [AW-1:0]         fetch_addr;
    logic [AW-1:0]         wr_addr;
    logic [INST_WIDTH-1:0] fetch_word;
    logic [PC_WIDTH-1:0]   pc_inc;
    logic                  is_halt;

    assign pc_ext         = XW'(pc_p0);
    assign wr_ext         = XW'(i_inst_mem_addr);
    assign fetch_in_range = (pc_ext < XW'(MEM_DEPTH));
    assign wr_in_range    = (wr_ext < XW'(MEM_DEPTH));
    assign fetch_addr     = pc_ext[AW-1:0];
    assign wr_addr        = wr_ext[AW-1:0];
    assign fetch_word     = fetch_in_range ? mem[fetch_addr] : '0;
    assign pc_inc         = pc_p0 + PC_WIDTH'(1);
    assign is_halt        = HALT_EN && fetch_in_range && (fetch_word == HALT_WORD);

    // Memory write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (rst && i_write_inst_mem && wr_in_range)
            mem[wr_addr] <= i_inst_mem_data;
    end

    always_comb begin
        pc_d      = pc_p0;
        inst_d    = inst_p1;
        pc_next_d = pc_next_p1;
        vld_d     = vld_p1;
        halted_d  = halted_p1;
        if (!i_write_inst_mem && enable) begin
            if (i_PCSrc) begin
                pc_d     = i_PCBranch;
                inst_d   = '0;
                vld_d    = 1'b0;
                halted_d = 1'b0;
            end else if (i_jump && !i_stall) begin
                pc_d   = i_jump_addr;
                inst_d = '0;
                vld_d  = 1'b0;
            end else if (!i_stall) begin
                if (halted_p1) begin
                    inst_d = '0;
                    vld_d  = 1'b0;
                end else begin
                    inst_d    = fetch_word;
                    pc_next_d = pc_inc;
                    vld_d     = fetch_in_range;
                    // A HALT is delivered once, then the PC stays parked on it.
                    if (is_halt)
                        halted_d = 1'b1;
                    else
                        pc_d = pc_inc;
                end
            end
        end
    end

    // p0 -> p1: PC register and IF/ID output register
    always_ff @(posedge clk) begin
        if (!rst) begin
            pc_p0      <= '0;
            inst_p1    <= '0;
            pc_next_p1 <= '0;
            vld_p1     <= 1'b0;
            halted_p1  <= 1'b0;
        end else begin
            pc_p0      <= pc_d;
            inst_p1    <= inst_d;
            pc_next_p1 <= pc_next_d;
            vld_p1     <= vld_d;
            halted_p1  <= halted_d;
        end
    end

    assign o_PCNext      = pc_next_p1;
    assign o_instruction = inst_p1;
    assign o_valid       = vld_p1;
    assign o_halted      = halted_p1;

endmodule
